// File: rtl/mean_square_pkg.sv
// Shared definitions for the mean-square accumulator.
// Holds the FSM state type and the default sample width and window size.
package mean_square_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_LOG2_N = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ms_state_e;

endpackage

// File: rtl/sq_unit.sv
// Combinational signed square.
//   a_i  : signed DATA_W-bit sample
//   sq_o : unsigned 2*DATA_W-bit square (exact, including the most negative value)
module sq_unit #(
    parameter int DATA_W = mean_square_pkg::DEFAULT_DATA_W
) (
    input  logic signed [DATA_W-1:0]   a_i,
    output logic        [2*DATA_W-1:0] sq_o
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] prod;

    // The largest square is 2**(2*DATA_W-2), so a 2*DATA_W product never wraps
    // and its sign bit is always zero.
    assign a_ext = a_i;
    assign prod  = a_ext * a_ext;
    assign sq_o  = $unsigned(prod);

endmodule

// File: rtl/mean_square_accum.sv
// Mean square over a window of 2**LOG2_N samples.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : sample handshake, in_data is signed
//   out_valid / out_ready: result handshake, out_data = sum(x^2) >> LOG2_N
// Accepts N samples in ACCUM, then holds the result in HOLD until consumed.
module mean_square_accum
    import mean_square_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LOG2_N = DEFAULT_LOG2_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [2*DATA_W-1:0] out_data
);

    localparam int ACC_W = 2*DATA_W + LOG2_N;

    ms_state_e           state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [2*DATA_W-1:0] out_data_q, out_data_d;

    logic [2*DATA_W-1:0] square;
    logic [ACC_W-1:0]    sum;

    sq_unit #(.DATA_W(DATA_W)) u_sq (
        .a_i  (in_data),
        .sq_o (square)
    );

    assign sum       = acc_q + {{LOG2_N{1'b0}}, square};
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    // cnt all-ones marks the last sample of the window; the
                    // counter is cleared only when the result is consumed.
                    if (&cnt_q) begin
                        out_data_d = sum[LOG2_N +: 2*DATA_W];
                        state_d    = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mean_square_accum.sv
// Directed bench for mean_square_accum (DATA_W=16, LOG2_N=4).
module tb_mean_square_accum;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic        [31:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mean_square_accum #(.DATA_W(16), .LOG2_N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample after 'gap' idle cycles (random data on idle cycles)
    // and return just after the transferring edge.
    task automatic send(input logic signed [15:0] v, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send a full window, checking out_valid rises exactly after the 16th sample.
    task automatic window(input string tag, input logic signed [15:0] a,
                          input logic signed [15:0] b, input logic [31:0] exp);
        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? a : b, 0);
            if (i == 14) chk({tag, "_vld_early"}, 64'(out_valid), 64'd0);
        end
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  64'(out_data),  64'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // 16 x 3 -> 9, consumed on the next edge
        out_ready = 1'b1;
        window("w3", 16'sd3, 16'sd3, 32'd9);
        @(posedge clk); #1;
        chk("w3_consumed_vld", 64'(out_valid), 64'd0);
        chk("w3_consumed_rdy", 64'(in_ready),  64'd1);
        chk("w3_data_kept",    64'(out_data),  64'd9);

        // Most negative value squares exactly
        window("wneg", -16'sd32768, -16'sd32768, 32'd1073741824);
        @(posedge clk); #1;
        chk("wneg_consumed", 64'(out_valid), 64'd0);

        // 0..15 with random gaps: 1240 >> 4 = 77
        for (int i = 0; i < 16; i++) send(16'(i), int'($urandom_range(0, 3)));
        chk("ramp_vld",  64'(out_valid), 64'd1);
        chk("ramp_data", 64'(out_data),  64'd77);
        @(posedge clk); #1;

        // Backpressure: result held, 17th sample waits for the transfer
        out_ready = 1'b0;
        window("walt", 16'sd100, -16'sd100, 32'd10000);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'sd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_rdy",  64'(in_ready),  64'd0);
            chk("hold_vld",  64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data),  64'd10000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_vld", 64'(out_valid), 64'd0);
        chk("hold_release_rdy", 64'(in_ready),  64'd1);
        @(posedge clk); #1;           // the pending 7 is taken here
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) send(16'sd7, 0);
        chk("w7_vld",  64'(out_valid), 64'd1);
        chk("w7_data", 64'(out_data),  64'd49);
        @(posedge clk); #1;

        // Reset mid-window discards the partial sum
        for (int i = 0; i < 7; i++) send(16'sd1000, 0);
        chk("part_no_vld", 64'(out_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rdy", 64'(in_ready),  64'd1);
        chk("midrst_vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        window("w2", 16'sd2, 16'sd2, 32'd4);

        // Reset while holding drops the unconsumed result
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("holdrst_vld",  64'(out_valid), 64'd0);
        chk("holdrst_data", 64'(out_data),  64'd0);
        chk("holdrst_rdy",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        window("w5", 16'sd5, -16'sd4, 32'd20);   // (8*25 + 8*16) >> 4 = 328/16 = 20

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
